// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the flags type.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_ADC = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_SBB = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOT = 4'b0111,
    ALU_SHL = 4'b1000,
    ALU_SHR = 4'b1001,
    ALU_INC = 4'b1010,
    ALU_DEC = 4'b1011,
    ALU_CMP = 4'b1100
  } alu_op_e;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback result handshake plus writeback-to-register-file handshake.
interface alu_wb_if #(parameter int unsigned RD_W = 3);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_result;
  logic [3:0]      in_sel;
  logic [RD_W-1:0] in_rd;
  logic            in_c;
  logic            in_s;
  logic            in_v;
  logic            in_z;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_result;
  logic [RD_W-1:0] out_rd;

  modport master (
    output in_valid, in_result, in_sel, in_rd, in_c, in_s, in_v, in_z, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  in_valid, in_result, in_sel, in_rd, in_c, in_s, in_v, in_z, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );
endinterface

// File: rtl/alu_wb_stage_fifo.sv
// Power-of-two circular FIFO; pointers wrap naturally, occupancy counter gives full/empty.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: queues non-compare results for the register file and owns the C/S/V/Z flags.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_wb_if.slave     wb,
  output alu_flags_t  flags_q,
  output logic        carry_q
);
  localparam int unsigned W = 16 + RD_W;

  logic         full;
  logic         empty;
  logic         accept;
  logic         push;
  logic         pop;
  logic [W-1:0] head;

  // in_ready comes only from the occupancy register, so a pop cannot open a slot in the same cycle.
  assign wb.in_ready  = !full;
  assign wb.out_valid = !empty;
  assign accept       = wb.in_valid && !full;
  assign push         = accept && (wb.in_sel != ALU_CMP);
  assign pop          = !empty && wb.out_ready;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({wb.in_result, wb.in_rd}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign wb.out_result = head[W-1:RD_W];
  assign wb.out_rd     = head[RD_W-1:0];

  // Compares still update flags; only the writeback entry is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (accept) begin
      flags_q <= {wb.in_c, wb.in_s, wb.in_v, wb.in_z};
    end
  end

  assign carry_q = flags_q[FLAG_C];
endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_wb_stage;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned RD_W  = 3;

  typedef struct {
    logic [15:0]     res;
    logic [RD_W-1:0] rd;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  alu_flags_t flags_q;
  logic       carry_q;

  alu_wb_if #(.RD_W(RD_W)) bus ();

  alu_wb_stage #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .wb      (bus.slave),
    .flags_q (flags_q),
    .carry_q (carry_q)
  );

  always #5 clk = ~clk;

  ent_t       q[$];
  logic [3:0] mflags = 4'b0000;
  int         npass  = 0;
  int         ntotal = 0;

  // Drives one cycle of stimulus from a negedge, lets the edge happen, updates the model, returns at the next negedge.
  task automatic step(input logic v, input logic [15:0] res, input logic [3:0] sel,
                      input logic [RD_W-1:0] rd, input logic [3:0] f, input logic rdy);
    logic acc;
    logic popm;
    bus.in_valid  = v;
    bus.in_result = res;
    bus.in_sel    = sel;
    bus.in_rd     = rd;
    {bus.in_c, bus.in_s, bus.in_v, bus.in_z} = f;
    bus.out_ready = rdy;
    @(posedge clk);
    acc  = v && (q.size() < DEPTH);
    popm = rdy && (q.size() > 0);
    if (popm) void'(q.pop_front());
    if (acc) begin
      mflags = f;
      if (sel != 4'b1100) q.push_back('{res: res, rd: rd});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_result = '0; bus.in_sel = '0;
    bus.in_rd = '0; bus.in_c = 1'b0; bus.in_s = 1'b0; bus.in_v = 1'b0; bus.in_z = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ntotal++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else npass++;
    ntotal++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else npass++;
    ntotal++; if (flags_q !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags_q); else npass++;
    ntotal++; if (carry_q !== 1'b0) $display("FAIL reset_carry got %b want 0", carry_q); else npass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(1'b1, 16'h1234, ALU_ADD, 3'd3, 4'b1010, 1'b1);
    ntotal++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else npass++;
    ntotal++; if (bus.out_result !== 16'h1234) $display("FAIL basic_result got %h want 1234", bus.out_result); else npass++;
    ntotal++; if (bus.out_rd !== 3'd3) $display("FAIL basic_rd got %0d want 3", bus.out_rd); else npass++;
    ntotal++; if (flags_q !== 4'b1010) $display("FAIL basic_flags got %b want 1010", flags_q); else npass++;
    step(1'b0, 16'h0, ALU_ADD, 3'd0, 4'b0000, 1'b1);
    ntotal++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain got %b want 0", bus.out_valid); else npass++;
  endtask

  task automatic test_fill_drain();
    step(1'b1, 16'hAAAA, ALU_ADD, 3'd1, 4'b0000, 1'b0);
    ntotal++; if (bus.in_ready !== 1'b1) $display("FAIL fill_ready1 got %b want 1", bus.in_ready); else npass++;
    step(1'b1, 16'hBBBB, ALU_SUB, 3'd2, 4'b0000, 1'b0);
    ntotal++; if (bus.in_ready !== 1'b0) $display("FAIL fill_full got %b want 0", bus.in_ready); else npass++;
    step(1'b1, 16'hCCCC, ALU_XOR, 3'd4, 4'b0100, 1'b0);
    ntotal++; if (bus.out_result !== 16'hAAAA) $display("FAIL fill_hold_head got %h want aaaa", bus.out_result); else npass++;
    ntotal++; if (flags_q !== 4'b0000) $display("FAIL fill_hold_flags got %b want 0000", flags_q); else npass++;
    // Full with a pop this cycle: the offer must still be refused.
    step(1'b1, 16'hCCCC, ALU_XOR, 3'd4, 4'b0100, 1'b1);
    ntotal++; if (bus.out_result !== 16'hBBBB) $display("FAIL fill_pop1 got %h want bbbb", bus.out_result); else npass++;
    ntotal++; if (bus.in_ready !== 1'b1) $display("FAIL fill_slot got %b want 1", bus.in_ready); else npass++;
    ntotal++; if (flags_q !== 4'b0000) $display("FAIL fill_refused_flags got %b want 0000", flags_q); else npass++;
    step(1'b1, 16'hCCCC, ALU_XOR, 3'd4, 4'b0100, 1'b1);
    ntotal++; if (bus.out_result !== 16'hCCCC || bus.out_rd !== 3'd4)
      $display("FAIL fill_pop2 got %h/%0d want cccc/4", bus.out_result, bus.out_rd); else npass++;
    ntotal++; if (flags_q !== 4'b0100) $display("FAIL fill_accept_flags got %b want 0100", flags_q); else npass++;
    step(1'b0, 16'h0, ALU_ADD, 3'd0, 4'b0000, 1'b1);
    ntotal++; if (bus.out_valid !== 1'b0) $display("FAIL fill_empty got %b want 0", bus.out_valid); else npass++;
  endtask

  task automatic test_compare();
    step(1'b1, 16'h5555, ALU_CMP, 3'd5, 4'b0001, 1'b1);
    ntotal++; if (flags_q !== 4'b0001) $display("FAIL cmp_flags got %b want 0001", flags_q); else npass++;
    ntotal++; if (bus.out_valid !== 1'b0) $display("FAIL cmp_no_entry got %b want 0", bus.out_valid); else npass++;
    ntotal++; if (bus.in_ready !== 1'b1) $display("FAIL cmp_ready got %b want 1", bus.in_ready); else npass++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'hFFFF, ALU_ADD, 3'd1, 4'b1000, 1'b0);
    ntotal++; if (carry_q !== 1'b1) $display("FAIL adc_carry got %b want 1", carry_q); else npass++;
    step(1'b1, 16'h0001, ALU_ADC, 3'd2, 4'b0001, 1'b0);
    ntotal++; if (bus.out_result !== 16'hFFFF) $display("FAIL adc_head got %h want ffff", bus.out_result); else npass++;
    ntotal++; if (carry_q !== 1'b0 || flags_q !== 4'b0001) $display("FAIL adc_flags got %b want 0001", flags_q); else npass++;
    step(1'b0, 16'h0, ALU_ADD, 3'd0, 4'b0000, 1'b1);
    ntotal++; if (bus.out_result !== 16'h0001 || bus.out_rd !== 3'd2)
      $display("FAIL adc_second got %h/%0d want 0001/2", bus.out_result, bus.out_rd); else npass++;
    step(1'b0, 16'h0, ALU_ADD, 3'd0, 4'b0000, 1'b1);
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h7777, ALU_OR, 3'd6, 4'b1111, 1'b0);
    ntotal++; if (flags_q !== 4'b1111) $display("FAIL arst_pre_flags got %b want 1111", flags_q); else npass++;
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    ntotal++; if (bus.out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", bus.out_valid); else npass++;
    ntotal++; if (flags_q !== 4'b0000 || carry_q !== 1'b0) $display("FAIL arst_flags got %b/%b want 0000/0", flags_q, carry_q); else npass++;
    q.delete();
    mflags = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'h4242, ALU_AND, 3'd7, 4'b0010, 1'b1);
    ntotal++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h4242 || bus.out_rd !== 3'd7)
      $display("FAIL arst_after got %b/%h/%0d want 1/4242/7", bus.out_valid, bus.out_result, bus.out_rd); else npass++;
    step(1'b0, 16'h0, ALU_ADD, 3'd0, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom_range(0, 12)),
           RD_W'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0));
      ntotal++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < DEPTH) ||
          flags_q !== mflags || carry_q !== mflags[3] ||
          (q.size() > 0 && (bus.out_result !== q[0].res || bus.out_rd !== q[0].rd))) begin
        if (bad < 10)
          $display("FAIL rand_cycle%0d got v=%b r=%b f=%b res=%h rd=%0d want v=%b r=%b f=%b res=%h rd=%0d",
                   i, bus.out_valid, bus.in_ready, flags_q, bus.out_result, bus.out_rd,
                   q.size() > 0, q.size() < DEPTH, mflags,
                   (q.size() > 0) ? q[0].res : 16'h0, (q.size() > 0) ? q[0].rd : '0);
        bad++;
      end else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_drain();
    test_compare();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the 16-bit ALU. Captures each ALU result with its destination register index into a small FIFO and presents it to the register file over a valid/ready handshake. Also owns the architectural flag register (carry, sign, overflow, zero), which supplies the ALU's carry input for the next operation. Compare operations update flags only and never produce a writeback entry.

## Interface

Parameters:
- DEPTH, 2: FIFO entries; power of two, 2..16.
- RD_W, 3: destination register index width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result offered this cycle.
- in_ready  out  1  stage can accept; equals !full; does not depend on in_valid or in_sel.
- in_result  in  16  ALU result.
- in_sel  in  4  ALU operation code that produced in_result; 4'b1100 = compare.
- in_rd  in  RD_W  destination register index.
- in_c, in_s, in_v, in_z  in  1 each  ALU carry, sign, overflow, zero flags.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  register file accepts the head.
- out_result  out  16  head result.
- out_rd  out  RD_W  head destination index.
- flags_q  out  4  {C,S,V,Z} registered flags.
- carry_q  out  1  flags_q[3]; wired to the ALU carry input.

## Operation

- Accept: in_valid && in_ready at a rising edge.
- Every accepted operation loads flags_q with {in_c,in_s,in_v,in_z} on that edge, including compares.
- An accepted non-compare operation pushes {in_result,in_rd} at the write pointer. Write pointer increments modulo DEPTH.
- An accepted compare (in_sel == 4'b1100) pushes nothing; the FIFO state is unchanged.
- Pop: out_valid && out_ready. Read pointer increments modulo DEPTH.
- Occupancy count ranges 0..DEPTH, with width clog2(DEPTH)+1. full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- While full, in_ready = 0 even if a pop occurs in the same cycle (no pass-through). A compare offered while full also waits.
- out_result and out_rd are driven from the head entry. When empty, they hold the last read location; consumers must ignore them while out_valid = 0.
- Pop while empty and push while full cannot occur, because the handshake gates both.

## Timing

- Reset values: count = 0, both pointers = 0, out_valid = 0, in_ready = 1, flags_q = 4'b0000, carry_q = 0. FIFO storage is not reset.
- Reset asserted mid-operation discards all entries and clears the flags immediately (asynchronous). The first accept is possible on the first rising edge after rst deasserts.
- Latency: an entry accepted at edge N appears with out_valid = 1 after edge N, i.e. 1 cycle, when the FIFO was empty.
- Throughput: one accept and one pop per cycle.
- Flag visibility: flags_q and carry_q update on the accept edge. The next accepted operation therefore sees the previous operation's carry, so back-to-back add-with-carry chains work with no bubble.
- out_valid, in_ready and flags_q are registered or derived solely from registers. There is no combinational path from in_* to out_*.

## Structure

- Shared package alu_pkg:
  - ALU opcode constants (ALU_ADD … ALU_DEC, ALU_CMP = 4'b1100).
  - Flag index constants FLAG_C = 3, FLAG_S = 2, FLAG_V = 1, FLAG_Z = 0.
  - The 4-bit flags typedef.
- Sub-module wb_fifo (parametric DEPTH and width, push/pop/full/empty) holds the {result,rd} storage.
- alu_wb_stage itself holds the flag register, the compare filter and the handshake glue.

## Test plan

- Reset, then push ADD result 16'h1234, rd = 3, with out_ready = 1: out_valid rises 1 cycle later with out_result = 16'h1234, out_rd = 3; flags_q matches the inputs.
- With out_ready = 0, push 2 entries (DEPTH = 2): in_ready = 0 after the second accept. A third offer is held until out_ready = 1, after which the entries drain in order.
- Compare with in_z = 1, in_c = 0 while empty: flags_q = 4'b0001, out_valid stays 0, count stays 0.
- Back-to-back ADD with in_c = 1, then ADC: carry_q = 1 in the ADC cycle; the ADC entry is queued behind the ADD.
- Full FIFO with simultaneous out_ready = 1 and in_valid = 1: a pop occurs, the push is refused that cycle, and it is accepted the next cycle.
- rst pulsed while 1 entry is queued and flags = 4'b1111: out_valid = 0 and flags_q = 0 immediately, without waiting for a clock edge; after release, a new entry flows through with 1-cycle latency.
